// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    // Carry-out plus a sum wide enough for the largest legal WIDTH.
    typedef struct packed {
        logic                    c;
        logic [FA_MAX_WIDTH-1:0] s;
    } fa_result_t;

endpackage

// File: rtl/full_adder_bit_cell.sv
// One-bit combinational full-adder cell; the top chains WIDTH of these.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in and carry-out.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_bit_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_next[i]),
            .co (carry[i+1])
        );
    end

    // Result register: loads only on valid, so idle (possibly X) operands never reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_next;
                c_out <= carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench: a WIDTH=1 and a WIDTH=8 instance share clock/reset.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic       s1, co1, ov1;
    logic       v8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       co8, ov8;
`ifdef FULL_ADDER_OVF_EN
    logic       of1, of8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(ci1),
        .sum(s1), .c_out(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(ci8),
        .sum(s8), .c_out(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle, so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {c_out,sum} for (a,b,c_in) = index bits {a,b,c_in}, hand-tabulated
        logic [1:0] tbl1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        fa_result_t exp_r;

        // Reset
        step(); step();
        check("rst_sum1", s1, 0);   check("rst_co1", co1, 0);  check("rst_ov1", ov1, 0);
        check("rst_sum8", s8, 0);   check("rst_co8", co8, 0);  check("rst_ov8", ov8, 0);
`ifdef FULL_ADDER_OVF_EN
        check("rst_of1", of1, 0);   check("rst_of8", of8, 0);
`endif
        rst = 1'b0;

        // 1: 1+1+1
        v1 = 1; a1 = 1; b1 = 1; ci1 = 1;
        step();
        check("t1_sum", s1, 1); check("t1_co", co1, 1); check("t1_ov", ov1, 1);

        // 2: back-to-back 0+1, 1+0
        a1 = 0; b1 = 1; ci1 = 0;
        step();
        check("t2a_sum", s1, 1); check("t2a_co", co1, 0); check("t2a_ov", ov1, 1);
        a1 = 1; b1 = 0; ci1 = 0;
        step();
        check("t2b_sum", s1, 1); check("t2b_co", co1, 0); check("t2b_ov", ov1, 1);

        // 3: exhaustive WIDTH=1
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            a1 = idx[2]; b1 = idx[1]; ci1 = idx[0];
            step();
            check($sformatf("t3_%0d", i), {co1, s1}, tbl1[i]);
            check($sformatf("t3_ov_%0d", i), ov1, 1);
        end
        // idle with X operands: outputs hold the 1+1+1 result
        v1 = 0; a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
        step();
        check("t3_hold", {co1, s1}, 2'd3); check("t3_hold_ov", ov1, 0);
        step();
        check("t3_hold2", {co1, s1}, 2'd3);

        // 4: WIDTH=8 boundaries
        v8 = 1; a8 = 8'hFF; b8 = 8'h00; ci8 = 1;
        step();
        check("t4a_sum", s8, 8'h00); check("t4a_co", co8, 1); check("t4a_ov", ov8, 1);
`ifdef FULL_ADDER_OVF_EN
        check("t4a_of", of8, 0);
`endif
        a8 = 8'hA5; b8 = 8'h5A; ci8 = 0;
        step();
        check("t4b_sum", s8, 8'hFF); check("t4b_co", co8, 0);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1;     // max sum 0x1FF
        step();
        exp_r = '0; exp_r.c = 1'b1; exp_r.s[7:0] = 8'hFF;
        check("t4c_max", {co8, s8}, {exp_r.c, exp_r.s[7:0]});
`ifdef FULL_ADDER_OVF_EN
        check("t4c_of", of8, 0);
`endif
        // 6: overflow cases (sum/carry checked in every build)
        a8 = 8'h7F; b8 = 8'h01; ci8 = 0;
        step();
        check("t6a_sum", s8, 8'h80); check("t6a_co", co8, 0);
`ifdef FULL_ADDER_OVF_EN
        check("t6a_of", of8, 1);
`endif
        // idle: hold 0x80 (and ovf=1)
        v8 = 0; a8 = 'x; b8 = 'x; ci8 = 1'bx;
        step();
        check("t8_hold_sum", s8, 8'h80); check("t8_hold_co", co8, 0); check("t8_hold_ov", ov8, 0);
`ifdef FULL_ADDER_OVF_EN
        check("t8_hold_of", of8, 1);
`endif
        v8 = 1; a8 = 8'hFF; b8 = 8'h01; ci8 = 0;
        step();
        check("t6b_sum", s8, 8'h00); check("t6b_co", co8, 1);
`ifdef FULL_ADDER_OVF_EN
        check("t6b_of", of8, 0);
`endif
        a8 = 8'h80; b8 = 8'h80; ci8 = 0;    // -128 + -128 overflows
        step();
        check("t6c_sum", s8, 8'h00); check("t6c_co", co8, 1);
`ifdef FULL_ADDER_OVF_EN
        check("t6c_of", of8, 1);
`endif

        // 5: reset wins over a simultaneous valid load
        rst = 1; v1 = 1; a1 = 1; b1 = 1; ci1 = 1;
        v8 = 1; a8 = 8'h7F; b8 = 8'h01; ci8 = 1;
        step();
        check("t5_sum1", s1, 0); check("t5_co1", co1, 0); check("t5_ov1", ov1, 0);
        check("t5_sum8", s8, 0); check("t5_co8", co8, 0); check("t5_ov8", ov8, 0);
`ifdef FULL_ADDER_OVF_EN
        check("t5_of1", of1, 0); check("t5_of8", of8, 0);
`endif
        rst = 0; v1 = 0; v8 = 0;
        step();
        check("t5_post_sum8", s8, 0); check("t5_post_ov8", ov8, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
